// File: rtl/mem_access.sv
// MEM-stage load/store unit: single-outstanding req/ack bus master with byte lanes and a bus timeout.
// Optional MEM_ALIGN_CHECK_EN: misaligned half/word accesses are trapped instead of issued.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_mem,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic [1:0]  dbg_state_o
);
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic [31:0]           r_result;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_is_mem;
  logic                  w_misalign;
  logic                  w_timeout;
  logic [1:0]            w_a;
  logic [3:0]            w_be;
  logic [31:0]           w_store_data;
  logic [31:0]           w_load_ext;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  assign w_a         = mem_addr_i[1:0];
  assign w_is_mem    = w_is_load | w_is_store;
  assign w_byte      = bus_rdata_i[{w_a, 3'b000} +: 8];
  assign w_half      = w_a[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  assign dbg_state_o = r_state;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: w_is_load  = 1'b1;
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:                         w_is_store = 1'b1;
      default: w_is_load = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    case (aluop_i)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: w_misalign = w_a[0];
      EXE_LW_OP, EXE_SW_OP:             w_misalign = |w_a;
      default:                          w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Loads always fetch the full word; lane selection happens on the returned data.
  always_comb begin
    w_be         = 4'hF;
    w_store_data = reg2_i;
    case (aluop_i)
      EXE_SB_OP: begin
        w_be         = 4'b0001 << w_a;
        w_store_data = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        w_be         = w_a[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{reg2_i[15:0]}};
      end
      default: w_be = 4'hF;
    endcase
  end

  always_comb begin
    w_load_ext = '0;
    case (aluop_i)
      EXE_LB_OP:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: w_load_ext = {24'd0, w_byte};
      EXE_LH_OP:  w_load_ext = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: w_load_ext = {16'd0, w_half};
      EXE_LW_OP:  w_load_ext = bus_rdata_i;
      default:    w_load_ext = '0;
    endcase
  end

  // An ack in the expiry cycle takes priority, so expiry is only flagged without ack.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_BUSY) && !bus_ack_i &&
                     (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    stallreq_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          w_next       = w_misalign ? S_DONE : S_BUSY;
          stallreq_mem = rst;
          wreg_o       = 1'b0;
        end
      end
      S_BUSY: begin
        if (bus_ack_i || w_timeout) w_next = S_DONE;
        stallreq_mem = rst;
        wreg_o       = 1'b0;
      end
      S_DONE: begin
        w_next  = S_IDLE;
        wreg_o  = wreg_i & w_is_load & ~bus_err_o & ~misalign_o;
        wdata_o = r_result;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      bus_err_o   <= 1'b0;
      misalign_o  <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
    end else begin
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_is_mem && w_misalign) begin
            misalign_o <= 1'b1;
            r_result   <= '0;
          end else if (w_is_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= w_is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_be_o    <= w_be;
            bus_wdata_o <= w_store_data;
          end
        end
        S_BUSY: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            r_result  <= w_load_ext;
          end else if (w_timeout) begin
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            r_result  <= '0;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized loads/stores
// checked against an arithmetic byte-lane model.
module tb_mem_access;
  localparam int T = 4;
  localparam logic [7:0] OP_ADD = 8'b0010_0000;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, bus_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o, bus_req_o, bus_we_o, stallreq_mem, bus_err_o, misalign_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mem_access #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stallreq_mem(stallreq_mem), .bus_err_o(bus_err_o),
    .misalign_o(misalign_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit m_is_load(logic [7:0] op);
    return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
  endfunction

  function automatic int m_size(logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit m_signed(logic [7:0] op);
    return op == OP_LB || op == OP_LH;
  endfunction

  function automatic int m_offset(logic [7:0] op, logic [31:0] addr);
    int sz = m_size(op);
    int a  = int'(addr % 4);
    if (sz == 4) return 0;
    return (a / sz) * sz;
  endfunction

  function automatic bit m_misaligned(logic [7:0] op, logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return m_size(op) > 1 && (addr % m_size(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(logic [7:0] op, logic [31:0] addr, logic [31:0] rdata);
    int sz = m_size(op);
    longint unsigned span, v;
    if (sz == 4) return rdata;
    span = 64'd1 << (sz * 8);
    v = (64'(rdata) >> (m_offset(op, addr) * 8)) % span;
    if (m_signed(op) && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(logic [7:0] op, logic [31:0] addr);
    if (m_is_load(op)) return 4'hF;
    return 4'(((1 << m_size(op)) - 1) << m_offset(op, addr));
  endfunction

  function automatic logic [31:0] m_wdata(logic [7:0] op, logic [31:0] reg2);
    int sz = m_size(op);
    longint unsigned span, w;
    if (sz == 4) return reg2;
    span = 64'd1 << (sz * 8);
    w = 0;
    for (int i = 0; i < 4 / sz; i++) w = w | ((64'(reg2) % span) << (i * sz * 8));
    return w[31:0];
  endfunction

  // ---------------- driver: one memory transaction ----------------
  // ack_delay = BUSY cycle in which ack is driven (0 = never).
  task automatic run_txn(input string name, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] reg2, input logic [31:0] rdata, input int ack_delay);
    bit ld, mis, to;
    int busy, stalls;
    logic [4:0]  wd;
    logic [31:0] exp_w, got_exp;
    ld    = m_is_load(op);
    mis   = m_misaligned(op, addr);
    to    = !mis && (ack_delay == 0 || ack_delay > T);
    busy  = mis ? 0 : (to ? T : ack_delay);
    exp_w = (mis || to) ? 32'd0 : m_load(op, addr, rdata);
    wd    = 5'($urandom_range(1, 31));
    if (ld) exp_q.push_back(exp_w);

    @(posedge clk); #1;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; bus_rdata_i = rdata;
    wd_i = wd; wreg_i = 1'b1; wdata_i = $urandom;
    @(negedge clk);
    stalls = 0;
    while (stallreq_mem === 1'b1 && stalls < 20) begin
      stalls++;
      n_checks++;
      if (bus_req_o !== (stalls >= 2 && !mis)) begin
        n_fail++; $display("FAIL %s/req@%0d: got %b expected %b", name, stalls, bus_req_o, stalls >= 2 && !mis);
      end
      n_checks++;
      if (wreg_o !== 1'b0) begin
        n_fail++; $display("FAIL %s/wreg_stall: got %b expected 0", name, wreg_o);
      end
      if (stalls == 2 && !mis) begin
        n_checks++;
        if (bus_addr_o !== {addr[31:2], 2'b00}) begin
          n_fail++; $display("FAIL %s/addr: got %h expected %h", name, bus_addr_o, {addr[31:2], 2'b00});
        end
        n_checks++;
        if (bus_be_o !== m_be(op, addr)) begin
          n_fail++; $display("FAIL %s/be: got %b expected %b", name, bus_be_o, m_be(op, addr));
        end
        n_checks++;
        if (bus_we_o !== !ld) begin
          n_fail++; $display("FAIL %s/we: got %b expected %b", name, bus_we_o, !ld);
        end
        if (!ld) begin
          n_checks++;
          if (bus_wdata_o !== m_wdata(op, reg2)) begin
            n_fail++; $display("FAIL %s/wdata: got %h expected %h", name, bus_wdata_o, m_wdata(op, reg2));
          end
        end
      end
      bus_ack_i = (ack_delay != 0 && stalls - 1 == ack_delay);
      @(posedge clk); #1 bus_ack_i = 1'b0;
      @(negedge clk);
    end

    // DONE cycle
    n_checks++;
    if (stalls !== 1 + busy) begin
      n_fail++; $display("FAIL %s/stall_cycles: got %0d expected %0d", name, stalls, 1 + busy);
    end
    n_checks++;
    if (wreg_o !== (ld && !mis && !to)) begin
      n_fail++; $display("FAIL %s/wreg_done: got %b expected %b", name, wreg_o, ld && !mis && !to);
    end
    n_checks++;
    if (wd_o !== wd) begin
      n_fail++; $display("FAIL %s/wd: got %0d expected %0d", name, wd_o, wd);
    end
    if (ld) begin
      got_exp = exp_q.pop_front();
      n_checks++;
      if (wdata_o !== got_exp) begin
        n_fail++; $display("FAIL %s/rdata: got %h expected %h", name, wdata_o, got_exp);
      end
    end
    n_checks++;
    if (bus_err_o !== to) begin
      n_fail++; $display("FAIL %s/bus_err: got %b expected %b", name, bus_err_o, to);
    end
    n_checks++;
    if (misalign_o !== mis) begin
      n_fail++; $display("FAIL %s/misalign: got %b expected %b", name, misalign_o, mis);
    end
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL %s/req_done: got %b expected 0", name, bus_req_o);
    end

    @(posedge clk); #1;
    aluop_i = OP_ADD;
    @(negedge clk);
    n_checks++;
    if ({bus_err_o, misalign_o, stallreq_mem, bus_req_o} !== 4'b0000) begin
      n_fail++; $display("FAIL %s/after_done: got %b expected 0000", name, {bus_err_o, misalign_o, stallreq_mem, bus_req_o});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0;
    aluop_i = OP_ADD; mem_addr_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
    wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req_o, bus_we_o, bus_err_o, misalign_o, stallreq_mem} !== 5'b0) begin
      n_fail++; $display("FAIL reset/flags: got %b expected 00000", {bus_req_o, bus_we_o, bus_err_o, misalign_o, stallreq_mem});
    end
    n_checks++;
    if ({bus_addr_o, bus_be_o, bus_wdata_o} !== 68'd0) begin
      n_fail++; $display("FAIL reset/bus: got %h %h %h expected 0", bus_addr_o, bus_be_o, bus_wdata_o);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset/state: got %0d expected 0 (idle)", dbg_state);
    end
    rst = 1'b1;
  endtask

  task automatic test_non_mem;
    @(posedge clk); #1;
    aluop_i = OP_ADD; wdata_i = 32'h1234; wd_i = 5'd3; wreg_i = 1'b1;
    #1;
    n_checks++;
    if (wdata_o !== 32'h1234) begin
      n_fail++; $display("FAIL non_mem/wdata: got %h expected 00001234", wdata_o);
    end
    n_checks++;
    if ({wd_o, wreg_o} !== {5'd3, 1'b1}) begin
      n_fail++; $display("FAIL non_mem/wd_wreg: got %0d %b expected 3 1", wd_o, wreg_o);
    end
    n_checks++;
    if ({stallreq_mem, bus_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL non_mem/stall_req: got %b expected 00", {stallreq_mem, bus_req_o});
    end
    for (int i = 0; i < 4; i++) begin
      wdata_i = $urandom; wd_i = 5'($urandom_range(0, 31)); wreg_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if ({wdata_o, wd_o, wreg_o} !== {wdata_i, wd_i, wreg_i}) begin
        n_fail++; $display("FAIL non_mem/rand%0d: got %h %0d %b expected %h %0d %b", i, wdata_o, wd_o, wreg_o, wdata_i, wd_i, wreg_i);
      end
    end
  endtask

  task automatic test_loads;
    run_txn("lb_signed",   OP_LB,  32'h8000_0003, 32'h0, 32'h80FF_0000, 3);
    run_txn("lbu_zero",    OP_LBU, 32'h8000_0003, 32'h0, 32'h80FF_0000, 3);
    run_txn("lh_upper",    OP_LH,  32'h0000_0042, 32'h0, 32'h9ABC_1234, 2);
    run_txn("lhu_lower",   OP_LHU, 32'h0000_0040, 32'h0, 32'h1234_F00D, 1);
    run_txn("lw_word",     OP_LW,  32'h0000_0044, 32'h0, 32'hCAFE_BABE, 2);
  endtask

  task automatic test_stores;
    run_txn("sh_upper",    OP_SH,  32'h0000_0102, 32'h0000_ABCD, 32'h0, 1);
    run_txn("sb_lane1",    OP_SB,  32'h0000_0201, 32'h1234_5677, 32'h0, 2);
    run_txn("sw_word",     OP_SW,  32'h0000_0208, 32'hDEAD_BEEF, 32'h0, 1);
  endtask

  task automatic test_timeout;
    run_txn("lw_timeout",  OP_LW,  32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn("ack_at_expiry", OP_LW, 32'h0000_0304, 32'h0, 32'h1357_9BDF, T);
  endtask

  task automatic test_reset_mid_busy;
    @(posedge clk); #1;
    aluop_i = OP_LW; mem_addr_i = 32'h0000_0400; wreg_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_req_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_busy/pre_req: got %b expected 1", bus_req_o);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_req_o, stallreq_mem} !== 2'b00) begin
      n_fail++; $display("FAIL rst_busy/async_drop: got %b expected 00", {bus_req_o, stallreq_mem});
    end
    aluop_i = OP_ADD; wdata_i = 32'h55AA_55AA; wd_i = 5'd9;
    #1 rst = 1'b1;
    bus_ack_i = 1'b1;
    @(posedge clk); #1 bus_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus_req_o, stallreq_mem, bus_err_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_busy/late_ack: got %b expected 000", {bus_req_o, stallreq_mem, bus_err_o});
    end
    n_checks++;
    if ({wreg_o, wdata_o} !== {1'b1, 32'h55AA_55AA}) begin
      n_fail++; $display("FAIL rst_busy/idle_pass: got %b %h expected 1 55aa55aa", wreg_o, wdata_o);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_busy/state: got %0d expected 0 (idle)", dbg_state);
    end
  endtask

  task automatic test_misalign;
    run_txn("sw_misaligned", OP_SW,  32'h0000_0102, 32'h0BAD_F00D, 32'h0, 1);
    run_txn("lh_odd",        OP_LH,  32'h0000_0105, 32'h0, 32'h8001_7FFE, 1);
  endtask

  task automatic test_random;
    logic [7:0] ops [8];
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    for (int i = 0; i < 24; i++) begin
      run_txn($sformatf("rand%0d", i), ops[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom, $urandom_range(1, T + 1));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_non_mem();
    test_loads();
    test_stores();
    test_timeout();
    test_reset_mid_busy();
    test_misalign();
    test_random();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard/leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
